// File: rtl/regbank_fwd.sv
// Decode-stage register bank with registered A/B operands and tag-compare forwarding.
// Sources are EX, DM and WB, in that priority. A load in EX that feeds an active source raises stall.
module regbank_fwd #(
  parameter int unsigned DW       = 16,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic          rd_en,
  input  logic [DW-1:0] imm,
  input  logic          imm_sel,
  input  logic          ex_we,
  input  logic          ex_ld,
  input  logic [AW-1:0] ex_wa,
  input  logic [DW-1:0] ex_data,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_wa,
  input  logic [DW-1:0] dm_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] a_q,
  output logic [DW-1:0] b_q,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          stall
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    SRC_FILE = 2'b00,
    SRC_EX   = 2'b01,
    SRC_DM   = 2'b10,
    SRC_WB   = 2'b11
  } src_e;

  logic [DW-1:0] regs_q [DEPTH];

  logic    a_zero, b_zero, a_active, b_active;
  logic [DW-1:0] a_d, b_d;
  src_e    a_src_d, b_src_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (we && !(ZERO_REG && (wa == '0))) begin
      regs_q[wa] <= wd;
    end
  end

  assign a_zero   = ZERO_REG && (ra == '0);
  assign b_zero   = ZERO_REG && (rb == '0);
  assign a_active = !a_zero;
  assign b_active = !b_zero && !imm_sel;

  assign stall = ex_we && ex_ld &&
                 ((a_active && (ex_wa == ra)) || (b_active && (ex_wa == rb)));

  always_comb begin
    a_d     = regs_q[ra];
    a_src_d = SRC_FILE;
    if (a_zero) begin
      a_d     = '0;
      a_src_d = SRC_FILE;
    end else if (ex_we && (ex_wa == ra)) begin
      a_d     = ex_data;
      a_src_d = SRC_EX;
    end else if (dm_we && (dm_wa == ra)) begin
      a_d     = dm_data;
      a_src_d = SRC_DM;
    end else if (we && (wa == ra)) begin
      a_d     = wd;
      a_src_d = SRC_WB;
    end
  end

  // The immediate overrides B before any tag compare, so rb cannot match while imm_sel is set.
  always_comb begin
    b_d     = regs_q[rb];
    b_src_d = SRC_FILE;
    if (imm_sel) begin
      b_d     = imm;
      b_src_d = SRC_FILE;
    end else if (b_zero) begin
      b_d     = '0;
      b_src_d = SRC_FILE;
    end else if (ex_we && (ex_wa == rb)) begin
      b_d     = ex_data;
      b_src_d = SRC_EX;
    end else if (dm_we && (dm_wa == rb)) begin
      b_d     = dm_data;
      b_src_d = SRC_DM;
    end else if (we && (wa == rb)) begin
      b_d     = wd;
      b_src_d = SRC_WB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      fwd_a <= SRC_FILE;
      fwd_b <= SRC_FILE;
    end else if (rd_en && !stall) begin
      a_q   <= a_d;
      b_q   <= b_d;
      fwd_a <= a_src_d;
      fwd_b <= b_src_d;
    end
  end

endmodule

// File: tb/tb_regbank_fwd.sv
// Directed self-checking bench for regbank_fwd: reset, write/read, priority, imm/r0, load-use, hold.
module tb_regbank_fwd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  ra, rb, ex_wa, dm_wa, wa;
  logic        rd_en, imm_sel, ex_we, ex_ld, dm_we, we;
  logic [15:0] imm, ex_data, dm_data, wd;
  logic [15:0] a_q, b_q;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall;

  int unsigned tests = 0;
  int unsigned fails = 0;

  regbank_fwd #(.DW(16), .AW(5), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .rd_en(rd_en),
    .imm(imm), .imm_sel(imm_sel),
    .ex_we(ex_we), .ex_ld(ex_ld), .ex_wa(ex_wa), .ex_data(ex_data),
    .dm_we(dm_we), .dm_wa(dm_wa), .dm_data(dm_data),
    .we(we), .wa(wa), .wd(wd),
    .a_q(a_q), .b_q(b_q), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ra = '0; rb = '0; rd_en = 1'b1; imm = '0; imm_sel = 1'b0;
    ex_we = 1'b0; ex_ld = 1'b0; ex_wa = '0; ex_data = '0;
    dm_we = 1'b0; dm_wa = '0; dm_data = '0;
    we = 1'b0; wa = '0; wd = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    tests++; if (a_q !== 16'h0000) begin fails++; $display("FAIL reset_a_init a_q=%h exp=0000", a_q); end
    tests++; if (fwd_b !== 2'b00)  begin fails++; $display("FAIL reset_fwdb_init fwd_b=%b exp=00", fwd_b); end
    #10 rst_n = 1'b1;
    we = 1'b1; wa = 5'd5; wd = 16'h1234;
    tick();
    we = 1'b0; ra = 5'd5;
    tick();
    tests++; if (a_q !== 16'h1234) begin fails++; $display("FAIL reset_pre_read a_q=%h exp=1234", a_q); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (a_q !== 16'h0000) begin fails++; $display("FAIL reset_async a_q=%h exp=0000", a_q); end
    #1 rst_n = 1'b1;
    tick();
    tests++; if (a_q !== 16'h0000) begin fails++; $display("FAIL reset_reg5_cleared a_q=%h exp=0000", a_q); end
    tests++; if (fwd_a !== 2'b00)  begin fails++; $display("FAIL reset_reg5_code fwd_a=%b exp=00", fwd_a); end
  endtask

  task automatic test_write_read();
    idle_inputs();
    we = 1'b1; wa = 5'd3; wd = 16'hBEEF; ra = 5'd0;
    tick();
    we = 1'b0; ra = 5'd3;
    tick();
    tests++; if (a_q !== 16'hBEEF) begin fails++; $display("FAIL wr_file a_q=%h exp=BEEF", a_q); end
    tests++; if (fwd_a !== 2'b00)  begin fails++; $display("FAIL wr_file_code fwd_a=%b exp=00", fwd_a); end
    we = 1'b1; wa = 5'd9; wd = 16'hCAFE; ra = 5'd9;
    tick();
    we = 1'b0;
    tests++; if (a_q !== 16'hCAFE) begin fails++; $display("FAIL wr_bypass a_q=%h exp=CAFE", a_q); end
    tests++; if (fwd_a !== 2'b11)  begin fails++; $display("FAIL wr_bypass_code fwd_a=%b exp=11", fwd_a); end
    rb = 5'd9;
    tick();
    tests++; if (b_q !== 16'hCAFE) begin fails++; $display("FAIL wr_file_b b_q=%h exp=CAFE", b_q); end
  endtask

  task automatic test_priority();
    idle_inputs();
    ra = 5'd7; rb = 5'd7;
    ex_we = 1'b1; ex_wa = 5'd7; ex_data = 16'h1111;
    dm_we = 1'b1; dm_wa = 5'd7; dm_data = 16'h2222;
    we = 1'b1; wa = 5'd7; wd = 16'h3333;
    tick();
    tests++; if (a_q !== 16'h1111 || fwd_a !== 2'b01) begin fails++; $display("FAIL prio_ex_a a_q=%h fwd_a=%b exp=1111/01", a_q, fwd_a); end
    tests++; if (b_q !== 16'h1111 || fwd_b !== 2'b01) begin fails++; $display("FAIL prio_ex_b b_q=%h fwd_b=%b exp=1111/01", b_q, fwd_b); end
    ex_we = 1'b0;
    tick();
    tests++; if (a_q !== 16'h2222 || fwd_a !== 2'b10) begin fails++; $display("FAIL prio_dm_a a_q=%h fwd_a=%b exp=2222/10", a_q, fwd_a); end
    tests++; if (b_q !== 16'h2222 || fwd_b !== 2'b10) begin fails++; $display("FAIL prio_dm_b b_q=%h fwd_b=%b exp=2222/10", b_q, fwd_b); end
    dm_we = 1'b0; wd = 16'h4444;
    tick();
    tests++; if (a_q !== 16'h4444 || fwd_a !== 2'b11) begin fails++; $display("FAIL prio_wb_a a_q=%h fwd_a=%b exp=4444/11", a_q, fwd_a); end
    we = 1'b0;
    tick();
    tests++; if (a_q !== 16'h4444 || fwd_a !== 2'b00) begin fails++; $display("FAIL prio_file_a a_q=%h fwd_a=%b exp=4444/00", a_q, fwd_a); end
  endtask

  task automatic test_imm_zero();
    idle_inputs();
    ra = 5'd0; ex_we = 1'b1; ex_ld = 1'b1; ex_wa = 5'd0; ex_data = 16'hFFFF;
    imm_sel = 1'b1; imm = 16'h00A5;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL r0_load_stall stall=%b exp=0", stall); end
    tick();
    tests++; if (a_q !== 16'h0000 || fwd_a !== 2'b00) begin fails++; $display("FAIL r0_read a_q=%h fwd_a=%b exp=0000/00", a_q, fwd_a); end
    tests++; if (b_q !== 16'h00A5 || fwd_b !== 2'b00) begin fails++; $display("FAIL imm_b b_q=%h fwd_b=%b exp=00A5/00", b_q, fwd_b); end
    ex_ld = 1'b0; ex_wa = 5'd4; rb = 5'd4; imm = 16'h005A;
    tick();
    tests++; if (b_q !== 16'h005A || fwd_b !== 2'b00) begin fails++; $display("FAIL imm_no_match b_q=%h fwd_b=%b exp=005A/00", b_q, fwd_b); end
    ex_we = 1'b0; imm_sel = 1'b0;
    we = 1'b1; wa = 5'd0; wd = 16'hDEAD;
    tick();
    tests++; if (a_q !== 16'h0000 || fwd_a !== 2'b00) begin fails++; $display("FAIL r0_wb a_q=%h fwd_a=%b exp=0000/00", a_q, fwd_a); end
    we = 1'b0;
    tick();
    tests++; if (a_q !== 16'h0000) begin fails++; $display("FAIL r0_after_write a_q=%h exp=0000", a_q); end
  endtask

  task automatic test_load_use();
    idle_inputs();
    ra = 5'd3; rb = 5'd9;
    tick();
    tests++; if (a_q !== 16'hBEEF || b_q !== 16'hCAFE) begin fails++; $display("FAIL lu_pre a_q=%h b_q=%h exp=BEEF/CAFE", a_q, b_q); end
    rb = 5'd4; ex_we = 1'b1; ex_ld = 1'b1; ex_wa = 5'd4; ex_data = 16'h9999;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall stall=%b exp=1", stall); end
    tick();
    tests++; if (b_q !== 16'hCAFE || fwd_b !== 2'b00 || a_q !== 16'hBEEF) begin fails++; $display("FAIL lu_hold a_q=%h b_q=%h fwd_b=%b exp=BEEF/CAFE/00", a_q, b_q, fwd_b); end
    ex_we = 1'b0; ex_ld = 1'b0; dm_we = 1'b1; dm_wa = 5'd4; dm_data = 16'h0042;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_dm_nostall stall=%b exp=0", stall); end
    tick();
    tests++; if (b_q !== 16'h0042 || fwd_b !== 2'b10) begin fails++; $display("FAIL lu_dm_fwd b_q=%h fwd_b=%b exp=0042/10", b_q, fwd_b); end
    dm_we = 1'b0; ex_we = 1'b1; ex_ld = 1'b1; ex_wa = 5'd4; imm_sel = 1'b1; imm = 16'h0077;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_imm_nostall stall=%b exp=0", stall); end
    tick();
    tests++; if (b_q !== 16'h0077 || fwd_b !== 2'b00) begin fails++; $display("FAIL lu_imm_b b_q=%h fwd_b=%b exp=0077/00", b_q, fwd_b); end
    ra = 5'd4;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_a_stall stall=%b exp=1", stall); end
    ex_we = 1'b0; ex_ld = 1'b0; imm_sel = 1'b0;
  endtask

  task automatic test_hold();
    idle_inputs();
    ra = 5'd3;
    tick();
    tests++; if (a_q !== 16'hBEEF) begin fails++; $display("FAIL hold_pre a_q=%h exp=BEEF", a_q); end
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ra = (i == 0) ? 5'd9 : 5'd3;
      we = (i == 1); wa = 5'd3; wd = 16'h5A5A;
      ex_we = (i == 2); ex_ld = (i == 2); ex_wa = 5'd3;
      tick();
      tests++; if (a_q !== 16'hBEEF || fwd_a !== 2'b00) begin fails++; $display("FAIL hold_cycle%0d a_q=%h fwd_a=%b exp=BEEF/00", i, a_q, fwd_a); end
    end
    we = 1'b0; ex_we = 1'b0; ex_ld = 1'b0; rd_en = 1'b1; ra = 5'd3;
    tick();
    tests++; if (a_q !== 16'h5A5A || fwd_a !== 2'b00) begin fails++; $display("FAIL hold_release a_q=%h fwd_a=%b exp=5A5A/00", a_q, fwd_a); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_priority();
    test_imm_zero();
    test_load_use();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regbank_fwd.md
# regbank_fwd

Parametrised register file with registered operand outputs and automatic forwarding, the next generation of the decode-stage register bank. It holds 2**AW registers of DW bits, has one writeback port, and provides two registered operand outputs (A, B). Forwarding from the EX/DM/WB stages is resolved internally by destination-tag compare, so external mux selects are no longer needed. It also detects load-use hazards and raises a stall. It sits between instruction decode and the execute stage of the 16-bit pipeline.

## Interface
- DW, 16, data width of every register and operand
- AW, 5, address width; depth = 2**AW
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and never forwards

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ra, rb  in  AW  source register addresses
- rd_en  in  1  operand capture enable (low = hold outputs, pipeline stall from downstream)
- imm  in  DW  immediate operand
- imm_sel  in  1  1: B operand takes imm instead of register rb
- ex_we, ex_ld  in  1 each  EX-stage instruction writes a register / is a load
- ex_wa  in  AW; ex_data  in  DW  EX-stage destination and result
- dm_we  in  1; dm_wa  in  AW; dm_data  in  DW  DM-stage destination and result
- we  in  1; wa  in  AW; wd  in  DW  writeback port (WB stage)
- a_q, b_q  out  DW  registered operands
- fwd_a, fwd_b  out  2  registered source code of a_q/b_q: 00 file, 01 EX, 10 DM, 11 WB
- stall  out  1  combinational load-use hazard flag

## Operation
- Write: at posedge clk, if we and not (ZERO_REG and wa==0), reg[wa] <= wd.
- Source selection for A, evaluated combinationally:
  - Priority EX > DM > WB > file. A match needs `<stage>_we` and `<stage>_wa == ra`.
  - With ZERO_REG=1 and ra==0: value 0, code 00, regardless of matches.
  - EX match returns ex_data (code 01). DM match returns dm_data (10). WB match returns wd (11, write-through bypass). Otherwise reg[ra] (00).
- B: same rule on rb. If imm_sel, B value = imm, fwd_b = 00, and rb never matches.
- Load-use hazard: stall = ex_we & ex_ld & ex_wa matches an active source.
  - A source is active if it is not register 0 under ZERO_REG. rb is active only when imm_sel=0.
  - No hazard exists for loads in DM (dm_data valid).
- Capture: at posedge, if rd_en & !stall, a_q/b_q/fwd_a/fwd_b <= selected values. Otherwise all four hold.
- Forwarded ex_data is ignored whenever stall is high.

## Timing
- Async reset (rst_n low), taking effect immediately:
  - All registers 0.
  - a_q = b_q = 0, fwd_a = fwd_b = 00.
  - stall follows its inputs (combinational).
- Deassertion is sampled at the next posedge; no writes occur while rst_n is low.
- Read latency: 1 cycle. Operands presented at edge N appear on a_q/b_q after edge N.
- Write latency: a write at edge N is visible via the file path for reads captured at edge N+1 or later. Same-edge read/write of one address is served by the WB bypass, so there is no stale read.
- Simultaneous EX, DM and WB writes to the same address as ra: EX value wins.
- Stall holds for as long as the hazard inputs persist. Exactly one bubble is required per load-use (the upstream pipeline advances ex_*).
- rd_en low and stall high together: outputs hold; a write still completes.
- Address wrap: none. Addresses are AW bits, all values are legal.
- ZERO_REG=0: register 0 is an ordinary register.

## Test plan
- Reset: write reg5=0x1234, assert rst_n low mid-cycle.
  - a_q = 0 immediately; after release, reading ra=5 gives a_q=0x0000, fwd_a=00.
- Write/read: we=1, wa=3, wd=0xBEEF at edge N; ra=3 at edge N+1.
  - a_q=0xBEEF, fwd_a=00. With ra=3 at edge N instead: a_q=0xBEEF, fwd_a=11.
- Priority: ra=rb=7, ex_we/dm_we/we all set with wa=7, ex_data=0x1111, dm_data=0x2222, wd=0x3333.
  - a_q = b_q = 0x1111, codes 01. Drop ex_we: 0x2222, codes 10.
- Immediate and zero register: ZERO_REG=1, ra=0, ex_we=1, ex_wa=0, ex_data=0xFFFF, imm_sel=1, imm=0x00A5.
  - a_q=0, fwd_a=00, b_q=0x00A5, stall=0. A write to r0 leaves r0 reading 0.
- Load-use: ex_we=ex_ld=1, ex_wa=4, rb=4, imm_sel=0.
  - stall=1, outputs hold. Next cycle the load moves to DM with dm_data=0x0042: stall=0, b_q=0x0042, fwd_b=10.
  - Same case with imm_sel=1: stall=0.
- Hold: rd_en=0 for 3 cycles while ra changes and a write to ra occurs.
  - a_q unchanged. After rd_en=1, a_q shows the written value.
